rgb_luma_pipe: RTL and testbench

RGB_LUMA_PIPE -- requirements
Module: rgb_luma_pipe

---
 rtl/rgb_luma_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_rgb_luma_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_luma_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rgb_luma_pipe                                              |
// | Description : Streaming RGB -> single-channel converter. A three-stage   |
// |               non-stalling pipeline (operands, weighted sum / max,       |
// |               round+clamp) feeds an output FIFO that absorbs downstream  |
// |               backpressure. The conversion mode is latched per frame.    |
// | Ports       : axi_clk, axi_reset    clock, sync active-high reset        |
// |               i_mode                conversion mode (latched at pixel 0) |
// |               i_rgb_data_valid/i_rgb_data/o_rgb_data_ready  input stream |
// |               o_grey_data_valid/o_grey_data/o_grey_last/i_grey_ready     |
// |                                     output stream                        |
// |               o_frame_done          pulse after a frame's last beat      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rgb_luma_pipe #(
  parameter int CH_W         = 8,
  parameter int FRAME_PIXELS = 262144,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic [1:0]        i_mode,
  input  logic              i_rgb_data_valid,
  input  logic [3*CH_W-1:0] i_rgb_data,
  output logic              o_rgb_data_ready,
  output logic              o_grey_data_valid,
  output logic [CH_W-1:0]   o_grey_data,
  output logic              o_grey_last,
  input  logic              i_grey_ready,
  output logic              o_frame_done
);

  localparam int SUM_W = CH_W + 10;
  localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int LVL_W = PTR_W + 2;

  localparam logic [PIX_W-1:0] LAST_PIX    = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [LVL_W-1:0] READY_LIMIT = LVL_W'(FIFO_DEPTH - 4);
  localparam logic [CH_W-1:0]  SAT         = '1;

  // ---------------------------------------------------------------- input
  logic             ready_q, ready_d;
  logic             accept;
  logic [PIX_W-1:0] pix_cnt_q;
  logic [1:0]       mode_q;
  logic [1:0]       pix_mode;

  assign accept   = i_rgb_data_valid & ready_q;
  // Pixel 0 uses the live mode; it is the value being latched for the frame.
  assign pix_mode = (pix_cnt_q == '0) ? i_mode : mode_q;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      pix_cnt_q <= '0;
      mode_q    <= 2'd0;
    end else if (accept) begin
      if (pix_cnt_q == '0) mode_q <= i_mode;
      pix_cnt_q <= (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + PIX_W'(1);
    end
  end

  // -------------------------------------------------------------- stage 1
  logic            s1_vld_q, s1_last_q;
  logic [1:0]      s1_mode_q;
  logic [CH_W-1:0] s1_r_q, s1_g_q, s1_b_q;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_mode_q <= 2'd0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
    end else begin
      s1_vld_q  <= accept;
      s1_last_q <= (pix_cnt_q == LAST_PIX);
      s1_mode_q <= pix_mode;
      s1_r_q    <= i_rgb_data[CH_W-1:0];
      s1_g_q    <= i_rgb_data[2*CH_W-1:CH_W];
      s1_b_q    <= i_rgb_data[3*CH_W-1:2*CH_W];
    end
  end

  // -------------------------------------------------------------- stage 2
  // Mode 0 is scaled by 64 so all weighted modes share one /256 rounding
  // path: (64R+128G+64B+128)>>8 == (R+2G+B+2)>>2 exactly.
  logic [SUM_W-1:0] coef_r, coef_g, coef_b;
  logic [CH_W-1:0]  max_rg, max_rgb;
  logic [SUM_W-1:0] s2_val_d, s2_val_q;
  logic             s2_vld_q, s2_last_q, s2_max_q;

  always_comb begin
    coef_r = SUM_W'(0);
    coef_g = SUM_W'(0);
    coef_b = SUM_W'(0);
    case (s1_mode_q)
      2'd0: begin coef_r = SUM_W'(64); coef_g = SUM_W'(128); coef_b = SUM_W'(64); end
      2'd1: begin coef_r = SUM_W'(77); coef_g = SUM_W'(150); coef_b = SUM_W'(29); end
      2'd2: begin coef_r = SUM_W'(54); coef_g = SUM_W'(183); coef_b = SUM_W'(19); end
      default: ;
    endcase
    max_rg  = (s1_r_q > s1_g_q) ? s1_r_q : s1_g_q;
    max_rgb = (max_rg > s1_b_q) ? max_rg : s1_b_q;
    if (s1_mode_q == 2'd3) begin
      s2_val_d = SUM_W'(max_rgb);
    end else begin
      s2_val_d = coef_r * SUM_W'(s1_r_q) + coef_g * SUM_W'(s1_g_q)
               + coef_b * SUM_W'(s1_b_q) + SUM_W'(128);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_max_q  <= 1'b0;
      s2_val_q  <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_max_q  <= (s1_mode_q == 2'd3);
      s2_val_q  <= s2_val_d;
    end
  end

  // ---------------------------------------------- stage 3: round / clamp
  logic [SUM_W-1:0] shifted;
  logic [CH_W-1:0]  result;
  logic [CH_W:0]    wdata;

  always_comb begin
    shifted = s2_val_q >> 8;
    if (s2_max_q)                     result = s2_val_q[CH_W-1:0];
    else if (shifted > SUM_W'(SAT))   result = SAT;
    else                              result = shifted[CH_W-1:0];
  end

  assign wdata = {s2_last_q, result};

  // ------------------------------------------------------------ out FIFO
  // head_q mirrors mem_q[rd_ptr_q] while non-empty and keeps its last value
  // when the FIFO drains, so the output data is always a plain register.
  logic [CH_W:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CH_W:0]      head_q, head_d;
  logic               push, pop;
  logic               frame_done_q;
  logic [LVL_W-1:0]   lvl_d;

  assign push = s2_vld_q;
  assign pop  = o_grey_data_valid & i_grey_ready;

  always_comb begin
    occ_d   = occ_q + OCC_W'(push) - OCC_W'(pop);
    rd_next = rd_ptr_q + PTR_W'(pop);
    head_d  = head_q;
    if (occ_d != '0) begin
      if ((occ_q - OCC_W'(pop)) == '0) head_d = wdata;
      else                             head_d = mem_q[rd_next];
    end
    // Level after this edge: FIFO entries plus both pipeline valids.
    lvl_d   = LVL_W'(occ_d) + LVL_W'(accept) + LVL_W'(s1_vld_q);
    ready_d = (lvl_d <= READY_LIMIT);
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      head_q       <= '0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q     <= rd_next;
      occ_q        <= occ_d;
      head_q       <= head_d;
      ready_q      <= ready_d;
      frame_done_q <= pop & head_q[CH_W];
    end
  end

  assign o_rgb_data_ready  = ready_q;
  assign o_grey_data_valid = (occ_q != '0);
  assign o_grey_data       = head_q[CH_W-1:0];
  assign o_grey_last       = head_q[CH_W];
  assign o_frame_done      = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_luma_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rgb_luma_pipe                                           |
// | Description : Scoreboard bench for rgb_luma_pipe (8-pixel frames,        |
// |               8-entry FIFO).                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_rgb_luma_pipe;

  localparam int CH_W = 8;
  localparam int FP   = 8;
  localparam int FD   = 8;

  logic          axi_clk = 1'b0;
  logic          axi_reset = 1'b1;
  logic [1:0]    i_mode = 2'd0;
  logic          i_rgb_data_valid = 1'b0;
  logic [23:0]   i_rgb_data = '0;
  logic          o_rgb_data_ready;
  logic          o_grey_data_valid;
  logic [7:0]    o_grey_data;
  logic          o_grey_last;
  logic          i_grey_ready = 1'b1;
  logic          o_frame_done;

  rgb_luma_pipe #(.CH_W(CH_W), .FRAME_PIXELS(FP), .FIFO_DEPTH(FD)) u_dut (
    .axi_clk          (axi_clk),
    .axi_reset        (axi_reset),
    .i_mode           (i_mode),
    .i_rgb_data_valid (i_rgb_data_valid),
    .i_rgb_data       (i_rgb_data),
    .o_rgb_data_ready (o_rgb_data_ready),
    .o_grey_data_valid(o_grey_data_valid),
    .o_grey_data      (o_grey_data),
    .o_grey_last      (o_grey_last),
    .i_grey_ready     (i_grey_ready),
    .o_frame_done     (o_frame_done)
  );

  always #5 axi_clk = ~axi_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard entries are {last, data}
  logic [8:0] sb[$];
  int         last_pos[$];
  int         m_cnt, out_idx, n_done, n_valid, n_both, n_stall, max_lvl;
  logic [1:0] m_mode;
  logic       exp_done, hold_pend, saw_ready_low;
  logic [8:0] hold_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_luma(input logic [1:0] m, input int r, input int g, input int b);
    int v;
    case (m)
      2'd0: v = (r + 2*g + b + 2) >> 2;
      2'd1: v = (77*r + 150*g + 29*b + 128) >> 8;
      2'd2: v = (54*r + 183*g + 19*b + 128) >> 8;
      default: begin
        v = r;
        if (g > v) v = g;
        if (b > v) v = b;
      end
    endcase
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  // One observation per clock, taken at the falling edge.
  task automatic mon();
    logic [8:0] e;
    logic       acc, xfer;
    if (axi_reset) begin
      sb.delete(); last_pos.delete();
      m_cnt = 0; m_mode = 2'd0; out_idx = 0; n_done = 0; n_valid = 0;
      n_both = 0; n_stall = 0; max_lvl = 0;
      exp_done = 1'b0; hold_pend = 1'b0; saw_ready_low = 1'b0;
      return;
    end
    acc  = i_rgb_data_valid && o_rgb_data_ready;
    xfer = o_grey_data_valid && i_grey_ready;
    if (exp_done || o_frame_done) check_eq("frame_done", o_frame_done, exp_done);
    if (o_frame_done) n_done++;
    exp_done = 1'b0;
    if (hold_pend) begin
      check_eq("hold_valid", o_grey_data_valid, 1);
      check_eq("hold_data", {o_grey_last, o_grey_data}, hold_val);
    end
    hold_pend = o_grey_data_valid && !i_grey_ready;
    hold_val  = {o_grey_last, o_grey_data};
    if (o_grey_data_valid) n_valid++;
    if (i_rgb_data_valid && !o_rgb_data_ready) begin
      saw_ready_low = 1'b1;
      n_stall++;
    end
    if (acc && xfer) n_both++;
    if (acc) begin
      if (m_cnt == 0) m_mode = i_mode;
      sb.push_back({(m_cnt == FP-1), ref_luma(m_mode, int'(i_rgb_data[7:0]),
                    int'(i_rgb_data[15:8]), int'(i_rgb_data[23:16]))});
      m_cnt = (m_cnt == FP-1) ? 0 : m_cnt + 1;
    end
    if (xfer) begin
      check_eq("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("out_data", o_grey_data, e[7:0]);
        check_eq("out_last", o_grey_last, e[8]);
      end
      exp_done = o_grey_last;
      if (o_grey_last) last_pos.push_back(out_idx);
      out_idx++;
    end
    if (sb.size() > max_lvl) max_lvl = sb.size();
  endtask

  task automatic tick();
    @(negedge axi_clk);
    mon();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic send_pix(input logic [1:0] m, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int guard;
    guard = 0;
    i_mode = m;
    i_rgb_data = {b, g, r};
    i_rgb_data_valid = 1'b1;
    while (!o_rgb_data_ready && guard < 500) begin
      tick();
      guard++;
    end
    check_eq("send_ready", o_rgb_data_ready, 1);
    tick();
    i_rgb_data_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    check_eq("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    i_rgb_data_valid = 1'b0;
    i_grey_ready = 1'b1;
    tick();
    check_eq("rst_ready", o_rgb_data_ready, 0);
    check_eq("rst_valid", o_grey_data_valid, 0);
    check_eq("rst_data", o_grey_data, 0);
    check_eq("rst_last", o_grey_last, 0);
    check_eq("rst_done", o_frame_done, 0);
    axi_reset = 1'b0;
    tick();
    check_eq("ready_after_rst", o_rgb_data_ready, 1);
  endtask

  task automatic single(input logic [1:0] m, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic [7:0] exp, input string tag);
    int lat;
    do_reset();
    send_pix(m, r, g, b);
    lat = 0;
    while (!o_grey_data_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", lat + 1, 3);
    check_eq(tag, o_grey_data, exp);
    drain();
  endtask

  initial begin
    tick();
    tick();

    // directed conversions with known results
    single(2'd1, 8'd255, 8'd0,   8'd0,   8'd77,  "m1_red");
    single(2'd1, 8'd255, 8'd255, 8'd255, 8'd255, "m1_white");
    single(2'd0, 8'd10,  8'd20,  8'd31,  8'd20,  "m0_mix");
    single(2'd2, 8'd0,   8'd255, 8'd0,   8'd182, "m2_green");
    single(2'd3, 8'd12,  8'd200, 8'd99,  8'd200, "m3_max");

    // random stream with a 20-cycle downstream stall
    do_reset();
    fork
      begin
        for (int i = 0; i < 64; i++)
          send_pix(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      begin
        repeat (15) @(posedge axi_clk);
        #1 i_grey_ready = 1'b0;
        repeat (20) @(posedge axi_clk);
        #1 i_grey_ready = 1'b1;
      end
    join
    drain();
    check_eq("stream_count", out_idx, 64);
    check_eq("stream_ready_drop", saw_ready_low, 1);
    check_eq("stream_inflight_bound", (max_lvl <= FD), 1);

    // two frames, mode switched mid-frame 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 5)
        send_pix(2'd1, 8'd255, 8'd0, 8'd0);
      else
        send_pix((i < 3) ? 2'd0 : 2'd1, 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    drain();
    check_eq("frame_last_n", last_pos.size(), 2);
    check_eq("frame_last0", (last_pos.size() > 0) ? last_pos[0] : -1, 7);
    check_eq("frame_last1", (last_pos.size() > 1) ? last_pos[1] : -1, 15);
    check_eq("frame_done_n", n_done, 2);

    // reset with beats buffered and in flight
    do_reset();
    i_grey_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_pix(2'd1, 8'(i * 40), 8'(i * 7), 8'(200 - i));
    do_reset();
    repeat (10) tick();
    check_eq("rst_flush_no_valid", n_valid, 0);
    for (int i = 0; i < FP; i++)
      send_pix(2'd2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain();
    check_eq("rst_frame_last_n", last_pos.size(), 1);
    check_eq("rst_frame_last0", (last_pos.size() > 0) ? last_pos[0] : -1, FP - 1);

    // sustained simultaneous input and output
    do_reset();
    for (int i = 0; i < 30; i++)
      send_pix(2'd3, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain();
    check_eq("steady_both", n_both, 27);
    check_eq("steady_no_stall", n_stall, 0);
    check_eq("steady_count", out_idx, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
